// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | data_mem_ctrl_if : request/response bus between a requester and the       |
// |                    data memory controller                                 |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | data_mem_ctrl : single-port word/byte data memory behind a valid/ready    |
// |                 request and response handshake with fixed wait states    |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module data_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int WAIT   = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  data_mem_ctrl_if.slave bus
);

  localparam int          c_bytes     = DATA_W / 8;
  localparam int          c_lane_bits = (c_bytes > 1) ? $clog2(c_bytes) : 0;
  localparam int          c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_lane_mask = 32'(c_bytes - 1);
  localparam logic [32:0] c_limit     = 33'(DEPTH) * 33'(c_bytes);
  localparam logic [2:0]  c_wait_m1   = 3'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;

  logic              r_write;
  logic              r_byte;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_cur_write;
  logic              w_cur_byte;
  logic [31:0]       w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata;
  logic [31:0]       w_lane;
  logic [c_idx_w-1:0] w_idx;
  logic              w_cur_err;
  logic              w_mem_we;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  assign w_accept = bus.req_valid && bus.req_ready;

  // With WAIT=0 the memory is accessed on the accepting edge itself, so the
  // live bus fields are used in IDLE and the captured ones afterwards.
  assign w_cur_write = (r_state == S_IDLE) ? bus.req_write : r_write;
  assign w_cur_byte  = (r_state == S_IDLE) ? bus.req_byte  : r_byte;
  assign w_cur_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;

  assign w_lane    = w_cur_addr & c_lane_mask;
  assign w_idx     = c_idx_w'(w_cur_addr >> c_lane_bits);
  assign w_cur_err = (!w_cur_byte && (w_lane != 32'd0)) ||
                     ({1'b0, w_cur_addr} >= c_limit);
  assign w_mem_we  = reset && w_enter_resp && w_cur_write && !w_cur_err;

  function automatic logic [DATA_W-1:0] pick_lane(input logic [DATA_W-1:0] word,
                                                  input logic [31:0]       lane);
    logic [DATA_W-1:0] shifted;
    shifted = word >> (lane * 32'd8);
    return DATA_W'(shifted[7:0]);
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT == 0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_wait_m1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_byte  <= bus.req_byte;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (w_enter_resp) begin
        r_err <= w_cur_err;
        if (w_cur_err || w_cur_write) begin
          r_rdata <= '0;
        end else if (w_cur_byte) begin
          r_rdata <= pick_lane(r_mem[w_idx], w_lane);
        end else begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (!w_cur_byte) begin
          r_mem[w_idx][b*8 +: 8] <= w_cur_wdata[b*8 +: 8];
        end else if (w_lane == 32'(b)) begin
          r_mem[w_idx][b*8 +: 8] <= w_cur_wdata[7:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_data_mem_ctrl : randomized bench for data_mem_ctrl against a byte-     |
// |                    array memory model | Revision 1.0                      |
// +---------------------------------------------------------------------------+
module tb_data_mem_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int WAIT  = 1;
  localparam int NBYTE = DEPTH * DW / 8;

  logic clk;
  logic reset;

  data_mem_ctrl_if #(.DATA_W(DW)) bus  ();
  data_mem_ctrl_if #(.DATA_W(DW)) bus0 ();
  data_mem_ctrl_if #(.DATA_W(DW)) bus7 ();

  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT(WAIT)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT(0))    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  data_mem_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT(7))    u_dut7 (.clk(clk), .reset(reset), .bus(bus7));

  logic [7:0] mref [0:NBYTE-1];
  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction on the main DUT; expectations come from the byte model.
  task automatic txn(input bit wr, input bit by, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [31:0] rd0;
    logic        er0;
    int          n;
    int          lat;
    bit          seen;
    exp_err = (!by && addr[1:0] != 2'd0) || (addr >= 32'(NBYTE));
    exp_rd  = 32'd0;
    if (!exp_err) begin
      if (wr) begin
        if (by) mref[addr[7:0]] = wd[7:0];
        else for (int k = 0; k < 4; k++) mref[addr[7:0] + 8'(k)] = wd[k*8 +: 8];
      end else if (by) begin
        exp_rd = {24'd0, mref[addr[7:0]]};
      end else begin
        exp_rd = {mref[addr[7:0] + 8'd3], mref[addr[7:0] + 8'd2],
                  mref[addr[7:0] + 8'd1], mref[addr[7:0]]};
      end
    end
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_byte  = by;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      lat++;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid) seen = 1'b1;
      else @(posedge clk);
    end
    chk("latency", 64'(lat), 64'(WAIT + 1));
    rd0 = bus.resp_rdata;
    er0 = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_byte  = 1'b0;
      bus.req_addr  = {$urandom_range(0, NBYTE / 4 - 1), 2'b00};
      bus.req_wdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_rdata", 64'(bus.resp_rdata), 64'(rd0));
      chk("hold_err",   64'(bus.resp_err),   64'(er0));
      chk("hold_ready", 64'(bus.req_ready),  64'd0);
    end
    bus.req_valid = 1'b0;
    chk("rdata", 64'(bus.resp_rdata), 64'(exp_rd));
    chk("err",   64'(bus.resp_err),   64'(exp_err));
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("post_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_ready", 64'(bus.req_ready),  64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    int          l0;
    int          l7;
    int          r;
    bit          wr;
    bit          by;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.req_valid = 0;  bus.req_write = 0;  bus.req_byte = 0;  bus.req_addr = 0;
    bus.req_wdata = 0;  bus.resp_ready = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_byte = 0; bus0.req_addr = 0;
    bus0.req_wdata = 0; bus0.resp_ready = 0;
    bus7.req_valid = 0; bus7.req_write = 0; bus7.req_byte = 0; bus7.req_addr = 0;
    bus7.req_wdata = 0; bus7.resp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_err",   64'(bus.resp_err),   64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);

    // Latency of the WAIT=0 and WAIT=7 variants, measured side by side.
    bus0.req_valid = 1; bus0.resp_ready = 1;
    bus7.req_valid = 1; bus7.resp_ready = 1;
    @(posedge clk);
    l0 = 0;
    l7 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus0.req_valid = 0;
      bus7.req_valid = 0;
      if (bus0.resp_valid && l0 == 0) l0 = c;
      if (bus7.resp_valid && l7 == 0) l7 = c;
    end
    chk("lat_wait0", 64'(l0), 64'd1);
    chk("lat_wait7", 64'(l7), 64'd8);
    chk("idle_wait7", 64'(bus7.req_ready), 64'd1);

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 1'b0, 32'(i * 4), $urandom, 0, rd, er);

    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, rd, er);
    chk("deadbeef", 64'(rd), 64'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h10, 32'h11223344, 0, rd, er);
    txn(1'b1, 1'b1, 32'h13, 32'h000000AA, 0, rd, er);
    txn(1'b0, 1'b1, 32'h13, 32'h0, 0, rd, er);
    chk("byte_load", 64'(rd), 64'h000000AA);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 5, rd, er);
    chk("merged_word", 64'(rd), 64'hAA223344);
    txn(1'b0, 1'b0, 32'h12, 32'h0, 0, rd, er);
    chk("misalign_err", 64'(er), 64'd1);
    txn(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 0, rd, er);
    chk("range_err", 64'(er), 64'd1);

    // Reset pulse while a store sits in WAIT: the store must be lost.
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_byte = 1;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_valid", 64'(bus.resp_valid), 64'd0);
    chk("abort_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("abort_err",   64'(bus.resp_err),   64'd0);
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 1'b1, 32'h20, 32'h0, 0, rd, er);

    // Reset pulse in RESP: response dropped, but the store already landed.
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_byte = 0;
    bus.req_addr = 32'h24; bus.req_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    chk("resp_pending", 64'(bus.resp_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("drop_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) mref[8'h24 + 8'(k)] = 8'(32'h0BADF00D >> (k * 8));
    txn(1'b0, 1'b0, 32'h24, 32'h0, 0, rd, er);
    chk("survived_store", 64'(rd), 64'h0BADF00D);

    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      by = 1'($urandom_range(0, 1));
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = $urandom_range(NBYTE, NBYTE + 40);
      else             addr = $urandom_range(0, NBYTE - 1);
      if (!by && $urandom_range(0, 3) != 0) addr = addr & ~32'd3;
      txn(wr, by, addr, $urandom, $urandom_range(0, 3), rd, er);
    end

    for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b0, 32'(i * 4), 32'h0, 0, rd, er);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
